nway_cache_control: RTL and testbench

- Parametrised controller for an N-way set-associative, write-back, write-allocate L2 cache.
- Sits between the L1/arbiter memory port and physical memory; drives the datapath's per-way load enables and mux selects.
- Keeps tree pseudo-LRU state internally, one entry per set, and picks victims with an invalid-first policy.
- Generalises the 2-way controller to WAYS ways, adds an asynchronous reset, a latched victim, saturating counters and a write-back counter.

---
 rtl/nway_cache_control_if.sv | 43 ++++
 rtl/nway_cache_control.sv | 202 ++++++++++++++++++++
 tb/tb_nway_cache_control.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nway_cache_control_if.sv
// Bus bundle between the L2 controller, the CPU-side port, physical memory and the cache datapath.
// The master modport is the controller's view; slave is the surrounding environment.
interface nway_cache_control_if #(
  parameter int WAYS   = 4,
  parameter int TAG_W  = 9,
  parameter int ADDR_W = 16
);
  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic              pmem_resp;
  logic [ADDR_W-1:0] pmem_address;

  logic [WAYS-1:0]       way_hit;
  logic [WAYS-1:0]       way_valid;
  logic [WAYS-1:0]       way_dirty;
  logic [WAYS*TAG_W-1:0] way_tag;
  logic [WAYS-1:0]       load_way;
  logic                  write_type;
  logic                  cache_in_mux_sel;
  logic                  insert_mux_sel;
  logic [VW-1:0]         victim_sel;

  modport master (
    input  mem_read, mem_write, mem_address, pmem_resp,
    input  way_hit, way_valid, way_dirty, way_tag,
    output mem_resp, pmem_read, pmem_write, pmem_address,
    output load_way, write_type, cache_in_mux_sel, insert_mux_sel, victim_sel
  );

  modport slave (
    output mem_read, mem_write, mem_address, pmem_resp,
    output way_hit, way_valid, way_dirty, way_tag,
    input  mem_resp, pmem_read, pmem_write, pmem_address,
    input  load_way, write_type, cache_in_mux_sel, insert_mux_sel, victim_sel
  );
endinterface

// File: rtl/nway_cache_control.sv
// N-way write-back/write-allocate L2 controller with tree PLRU; counters built under L2_PERF_CNT_EN.
// Hits respond in the same cycle; misses stall the held request through WRITEBACK/FETCH/FILL.
module nway_cache_control #(
  parameter int WAYS   = 4,
  parameter int IDX_W  = 3,
  parameter int OFF_W  = 4,
  parameter int TAG_W  = 9,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nway_cache_control_if.master bus,
  input  logic                 hit_count_reset,
  input  logic                 miss_count_reset,
  input  logic                 wb_count_reset,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic [CNT_W-1:0]     wb_count
);
  localparam int VW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SETS = 1 << IDX_W;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, FETCH, FILL} state_t;

  state_t            state;
  logic [VW-1:0]     victim_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [WAYS-1:1]   plru_q [SETS];

  logic [IDX_W-1:0]  idx;
  logic              req;
  logic              hit;
  logic [VW-1:0]     hit_way;
  logic [VW-1:0]     first_inv;
  logic              any_inv;
  logic [VW-1:0]     victim_c;
  logic [TAG_W-1:0]  victim_tag;

  // Each node on the accessed way's path points to the opposite half.
  function automatic logic [WAYS-1:1] plru_touch(input logic [WAYS-1:1] bits,
                                                 input logic [VW-1:0]   way);
    logic [WAYS-1:1] nxt;
    logic [VW-1:0]   node;
    nxt  = bits;
    node = VW'(1);
    for (int l = VW - 1; l >= 0; l--) begin
      nxt[node] = ~way[l];
      node      = (node << 1) | VW'(way[l]);
    end
    return nxt;
  endfunction

  function automatic logic [VW-1:0] plru_pick(input logic [WAYS-1:1] bits);
    logic [VW-1:0] node;
    logic [VW-1:0] way;
    node = VW'(1);
    way  = '0;
    for (int l = VW - 1; l >= 0; l--) begin
      way[l] = bits[node];
      node   = (node << 1) | VW'(way[l]);
    end
    return way;
  endfunction

  assign idx = bus.mem_address[OFF_W +: IDX_W];
  assign req = bus.mem_read | bus.mem_write;
  assign hit = |bus.way_hit;

  always_comb begin
    hit_way   = '0;
    first_inv = '0;
    any_inv   = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (bus.way_hit[w]) hit_way = VW'(w);
      if (!bus.way_valid[w]) begin
        first_inv = VW'(w);
        any_inv   = 1'b1;
      end
    end
  end

  assign victim_c   = any_inv ? first_inv : plru_pick(plru_q[idx]);
  assign victim_tag = bus.way_tag[int'(victim_c) * TAG_W +: TAG_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= COMPARE;
      victim_q     <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      wb_addr_q    <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      case (state)
        COMPARE: begin
          if (req && hit) begin
            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
          end else if (req) begin
            victim_q  <= victim_c;
            wb_addr_q <= {victim_tag, idx, {OFF_W{1'b0}}};
            if (bus.way_valid[victim_c] && bus.way_dirty[victim_c]) begin
              state        <= WRITEBACK;
              pmem_write_q <= 1'b1;
            end else begin
              state       <= FETCH;
              pmem_read_q <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            state        <= FETCH;
            pmem_write_q <= 1'b0;
            pmem_read_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.pmem_resp) begin
            state       <= FILL;
            pmem_read_q <= 1'b0;
          end
        end
        FILL: begin
          plru_q[idx] <= plru_touch(plru_q[idx], victim_q);
          state       <= COMPARE;
        end
        default: state <= COMPARE;
      endcase
    end
  end

  // Hit response and write-hit loads must be combinational for zero-cycle hits.
  always_comb begin
    bus.mem_resp         = 1'b0;
    bus.load_way         = '0;
    bus.write_type       = 1'b0;
    bus.cache_in_mux_sel = 1'b0;
    bus.insert_mux_sel   = 1'b0;
    if (!rst) begin
      case (state)
        COMPARE: begin
          if (req && hit) begin
            bus.mem_resp = 1'b1;
            if (bus.mem_write) begin
              bus.load_way         = WAYS'(1) << hit_way;
              bus.write_type       = 1'b1;
              bus.cache_in_mux_sel = 1'b1;
            end
          end
        end
        FILL: begin
          bus.load_way         = WAYS'(1) << victim_q;
          bus.insert_mux_sel   = 1'b1;
          bus.write_type       = bus.mem_write;
          bus.cache_in_mux_sel = bus.mem_write;
        end
        default: ;
      endcase
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.victim_sel   = victim_q;
  assign bus.pmem_address = (state == WRITEBACK) ? wb_addr_q
                          : {bus.mem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  logic unused_offset;
  assign unused_offset = ^bus.mem_address[OFF_W-1:0];

`ifdef L2_PERF_CNT_EN
  logic hit_inc, miss_inc, wb_inc;
  assign hit_inc  = (state == COMPARE) && req && hit;
  assign miss_inc = (state == FILL);
  assign wb_inc   = (state == WRITEBACK) && bus.pmem_resp;

  // Counter clears win over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_count_reset)                  hit_count  <= '0;
      else if (hit_inc && !(&hit_count))    hit_count  <= hit_count + CNT_W'(1);
      if (miss_count_reset)                 miss_count <= '0;
      else if (miss_inc && !(&miss_count))  miss_count <= miss_count + CNT_W'(1);
      if (wb_count_reset)                   wb_count   <= '0;
      else if (wb_inc && !(&wb_count))      wb_count   <= wb_count + CNT_W'(1);
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
  logic unused_cnt_resets;
  assign unused_cnt_resets = hit_count_reset ^ miss_count_reset ^ wb_count_reset;
`endif
endmodule

// File: tb/tb_nway_cache_control.sv
// Self-checking bench: datapath arrays around the controller plus a transaction-level reference model.
module tb_nway_cache_control;
  localparam int WAYS = 4, IDX_W = 3, OFF_W = 4, TAG_W = 9, ADDR_W = 16, CNT_W = 8;
  localparam int SETS = 1 << IDX_W;
  localparam int CMAX = (1 << CNT_W) - 1;
`ifdef L2_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic hit_count_reset, miss_count_reset, wb_count_reset;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;

  nway_cache_control_if #(.WAYS(WAYS), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) bus ();

  nway_cache_control #(.WAYS(WAYS), .IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W),
                       .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hit_count_reset(hit_count_reset), .miss_count_reset(miss_count_reset),
    .wb_count_reset(wb_count_reset),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Datapath: tag/valid/dirty storage loaded by the controller's strobes.
  logic [TAG_W-1:0] dp_tag   [SETS][WAYS];
  logic             dp_valid [SETS][WAYS];
  logic             dp_dirty [SETS][WAYS];
  logic             dp_clear;
  int               cur_s, cur_t;

  always_comb begin
    cur_s = int'(bus.mem_address[OFF_W +: IDX_W]);
    cur_t = int'(bus.mem_address[ADDR_W-1 -: TAG_W]);
    for (int w = 0; w < WAYS; w++) begin
      bus.way_valid[w] = dp_valid[cur_s][w];
      bus.way_dirty[w] = dp_dirty[cur_s][w];
      bus.way_tag[w*TAG_W +: TAG_W] = dp_tag[cur_s][w];
      bus.way_hit[w] = dp_valid[cur_s][w] && (dp_tag[cur_s][w] == TAG_W'(cur_t));
    end
  end

  always @(posedge clk) begin
    if (dp_clear) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          dp_tag[s][w] <= '0; dp_valid[s][w] <= 1'b0; dp_dirty[s][w] <= 1'b0;
        end
    end else begin
      for (int w = 0; w < WAYS; w++)
        if (bus.load_way[w]) begin
          dp_tag[cur_s][w]   <= TAG_W'(cur_t);
          dp_valid[cur_s][w] <= 1'b1;
          dp_dirty[cur_s][w] <= bus.write_type;
        end
    end
  end

  // Reference model state.
  int              m_tag   [SETS][WAYS];
  bit              m_valid [SETS][WAYS];
  bit              m_dirty [SETS][WAYS];
  bit [WAYS-1:0]   m_plru  [SETS];
  int              m_hits, m_miss, m_wb, m_vreg;
  int              n_checks = 0, n_errors = 0;
  string           phase = "reset";
  bit              rnd_mode = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", phase, n, act, exp);
    end
  endtask

  function automatic int cnt_next(input int c, input bit clr, input bit inc);
    if (clr) return 0;
    if (inc && c < CMAX) return c + 1;
    return c;
  endfunction

  function automatic int m_victim(input int s);
    int lo, sz, node;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    lo = 0; sz = WAYS; node = 1;
    while (sz > 1) begin
      sz = sz / 2;
      if (m_plru[s][node]) begin lo = lo + sz; node = 2 * node + 1; end
      else node = 2 * node;
    end
    return lo;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int lo, sz, node;
    lo = 0; sz = WAYS; node = 1;
    while (sz > 1) begin
      sz = sz / 2;
      if (w < lo + sz) begin m_plru[s][node] = 1'b1; node = 2 * node; end
      else begin m_plru[s][node] = 1'b0; lo = lo + sz; node = 2 * node + 1; end
    end
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) m_plru[s] = '0;
    m_hits = 0; m_miss = 0; m_wb = 0; m_vreg = 0;
  endfunction

  function automatic bit spur();
    return rnd_mode && ($urandom_range(0, 3) == 0);
  endfunction

  // One clock cycle: inputs already driven at the falling edge; check, advance model, wait.
  task automatic cycle(input bit e_resp, input bit e_prd, input bit e_pwr,
                       input logic [ADDR_W-1:0] e_pa, input logic [WAYS-1:0] e_ld,
                       input bit e_wt, input bit e_cim, input bit e_ins,
                       input bit hinc, input bit minc, input bit winc);
    if (rnd_mode) begin
      hit_count_reset  = ($urandom_range(0, 31) == 0);
      miss_count_reset = ($urandom_range(0, 31) == 0);
      wb_count_reset   = ($urandom_range(0, 31) == 0);
    end
    #1;
    chk("mem_resp",     32'(bus.mem_resp),         32'(e_resp));
    chk("pmem_read",    32'(bus.pmem_read),        32'(e_prd));
    chk("pmem_write",   32'(bus.pmem_write),       32'(e_pwr));
    chk("pmem_address", 32'(bus.pmem_address),     32'(e_pa));
    chk("load_way",     32'(bus.load_way),         32'(e_ld));
    chk("write_type",   32'(bus.write_type),       32'(e_wt));
    chk("cache_in_sel", 32'(bus.cache_in_mux_sel), 32'(e_cim));
    chk("insert_sel",   32'(bus.insert_mux_sel),   32'(e_ins));
    chk("victim_sel",   32'(bus.victim_sel),       32'(m_vreg));
    chk("hit_count",    32'(hit_count),  CNT_ON ? 32'(m_hits) : 32'd0);
    chk("miss_count",   32'(miss_count), CNT_ON ? 32'(m_miss) : 32'd0);
    chk("wb_count",     32'(wb_count),   CNT_ON ? 32'(m_wb)   : 32'd0);
    m_hits = cnt_next(m_hits, hit_count_reset, hinc);
    m_miss = cnt_next(m_miss, miss_count_reset, minc);
    m_wb   = cnt_next(m_wb,   wb_count_reset,   winc);
    @(negedge clk);
  endtask

  task automatic do_req(input logic [ADDR_W-1:0] addr, input bit rd, input bit wr,
                        input int wb_lat, input int f_lat, input bit abort);
    int s, t, hw, v;
    bit hit, dirty_v;
    logic [ADDR_W-1:0] al, wba;
    s  = int'(addr[OFF_W +: IDX_W]);
    t  = int'(addr[ADDR_W-1 -: TAG_W]);
    al = addr & ~ADDR_W'((1 << OFF_W) - 1);
    hit = 1'b0; hw = 0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; hw = w; end
    bus.mem_address = addr; bus.mem_read = rd; bus.mem_write = wr;
    if (!hit) begin
      v = m_victim(s);
      dirty_v = m_valid[s][v] && m_dirty[s][v];
      wba = ADDR_W'((m_tag[s][v] << (OFF_W + IDX_W)) | (s << OFF_W));
      bus.pmem_resp = spur();
      cycle(0, 0, 0, al, '0, 0, 0, 0, 0, 0, 0);
      m_vreg = v;
      if (dirty_v)
        for (int k = 0; k <= wb_lat; k++) begin
          bus.pmem_resp = (k == wb_lat);
          cycle(0, 0, 1, wba, '0, 0, 0, 0, 0, 0, k == wb_lat);
        end
      for (int k = 0; k <= f_lat; k++) begin
        bus.pmem_resp = (k == f_lat);
        cycle(0, 1, 0, al, '0, 0, 0, 0, 0, 0, 0);
        if (abort) begin
          chk("abort_pre_read", 32'(bus.pmem_read), 32'd1);
          rst = 1'b1;
          #1;
          chk("abort_read",  32'(bus.pmem_read),  32'd0);
          chk("abort_write", 32'(bus.pmem_write), 32'd0);
          chk("abort_load",  32'(bus.load_way),   32'd0);
          chk("abort_resp",  32'(bus.mem_resp),   32'd0);
          m_reset();
          @(negedge clk);
          rst = 1'b0;
          bus.pmem_resp = 1'b0;
          return;
        end
      end
      bus.pmem_resp = spur();
      cycle(0, 0, 0, al, WAYS'(1) << v, wr, wr, 1, 0, 1, 0);
      m_tag[s][v] = t; m_valid[s][v] = 1'b1; m_dirty[s][v] = wr;
      m_touch(s, v);
      hw = v;
    end
    bus.pmem_resp = spur();
    cycle(1, 0, 0, al, wr ? (WAYS'(1) << hw) : '0, wr, wr, 0, 1, 0, 0);
    m_touch(s, hw);
    if (wr) m_dirty[s][hw] = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] mk(input int tag, input int s, input int off);
    return ADDR_W'((tag << (OFF_W + IDX_W)) | (s << OFF_W) | off);
  endfunction

  initial begin
    rst = 1'b1; dp_clear = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0; bus.pmem_resp = 1'b0;
    hit_count_reset = 1'b0; miss_count_reset = 1'b0; wb_count_reset = 1'b0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin m_tag[s][w] = 0; m_valid[s][w] = 0; m_dirty[s][w] = 0; end
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp",  32'(bus.mem_resp),   32'd0);
    chk("rst_pread", 32'(bus.pmem_read),  32'd0);
    chk("rst_pwr",   32'(bus.pmem_write), 32'd0);
    chk("rst_load",  32'(bus.load_way),   32'd0);
    chk("rst_vsel",  32'(bus.victim_sel), 32'd0);
    chk("rst_hits",  32'(hit_count),      32'd0);
    @(negedge clk);
    rst = 1'b0; dp_clear = 1'b0;

    phase = "first_miss";
    chk("pin_first_victim", 32'(m_victim(4)), 32'd0);
    do_req(16'h0040, 1, 0, 0, 2, 0);
    #1;
    chk("t1_hits", 32'(hit_count),  CNT_ON ? 32'd1 : 32'd0);
    chk("t1_miss", 32'(miss_count), CNT_ON ? 32'd1 : 32'd0);
    chk("t1_way0", 32'(dp_valid[4][0]), 32'd1);

    phase = "plru";
    for (int t = 1; t < 4; t++) do_req(mk(t, 4, 0), 1, 0, 0, 1, 0);
    do_req(mk(0, 4, 3), 1, 0, 0, 1, 0);
    chk("pin_plru_victim", 32'(m_victim(4)), 32'd2);
    do_req(mk(4, 4, 0), 1, 0, 0, 1, 0);
    #1;
    chk("t2_evict_way2", 32'(dp_tag[4][2]), 32'd4);

    phase = "writeback";
    do_req(mk(1, 4, 8), 0, 1, 0, 1, 0);
    do_req(mk(0, 4, 0), 1, 0, 0, 1, 0);
    do_req(mk(3, 4, 0), 1, 0, 0, 1, 0);
    chk("pin_wb_victim", 32'(m_victim(4)), 32'd1);
    chk("pin_wb_addr", 32'((m_tag[4][1] << 7) | (4 << 4)), 32'h00C0);
    do_req(mk(5, 4, 0), 1, 0, 2, 1, 0);
    #1;
    chk("t3_wb_count", 32'(wb_count), CNT_ON ? 32'd1 : 32'd0);

    phase = "write_miss";
    chk("pin_clean_victim", 32'(m_victim(4)), 32'd2);
    do_req(mk(6, 4, 4), 0, 1, 0, 2, 0);
    #1;
    chk("t4_dirty", 32'(dp_dirty[4][2]), 32'd1);
    chk("t4_no_wb", 32'(wb_count), CNT_ON ? 32'd1 : 32'd0);

    phase = "saturate";
    hit_count_reset = 1'b1;
    do_req(mk(6, 4, 0), 1, 0, 0, 1, 0);
    hit_count_reset = 1'b0;
    #1;
    chk("t5_clear_beats_inc", 32'(hit_count), 32'd0);
    for (int i = 0; i < CMAX - 1; i++) do_req(mk(6, 4, 0), 1, 0, 0, 1, 0);
    #1;
    chk("t5_fe", 32'(hit_count), CNT_ON ? 32'(CMAX - 1) : 32'd0);
    for (int i = 0; i < 3; i++) do_req(mk(6, 4, 0), 1, 0, 0, 1, 0);
    #1;
    chk("t5_sat", 32'(hit_count), CNT_ON ? 32'(CMAX) : 32'd0);

    phase = "abort";
    do_req(mk(1, 0, 0), 1, 0, 0, 3, 1);
    chk("t6_not_loaded", 32'(dp_valid[0][0]), 32'd0);
    do_req(mk(1, 0, 0), 1, 0, 0, 2, 0);
    #1;
    chk("t6_replay_hits", 32'(hit_count),  CNT_ON ? 32'd1 : 32'd0);
    chk("t6_replay_miss", 32'(miss_count), CNT_ON ? 32'd1 : 32'd0);

    phase = "random";
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 2);
      do_req(mk($urandom_range(0, 5), $urandom_range(0, SETS - 1), $urandom_range(0, 15)),
             op != 1, op != 0, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.pmem_resp = spur();
        cycle(0, 0, 0, bus.mem_address & ~ADDR_W'(15), '0, 0, 0, 0, 0, 0, 0);
        bus.pmem_resp = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
